// File: rtl/hyperbus_port_arbiter.sv
// Multi-channel command front end for a hyperbus core: per-channel queues, a
// round-robin arbiter, halfword splitting of each command, read reassembly and a WAIT timeout.
module hyperbus_port_arbiter #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned DW      = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NCH-1:0]    cmd_valid,
    output logic [NCH-1:0]    cmd_ready,
    input  logic [NCH-1:0]    cmd_we,
    input  logic [NCH*32-1:0] cmd_adr,
    input  logic [NCH*DW-1:0] cmd_dat,
    output logic [NCH-1:0]    rsp_valid,
    output logic              rsp_err,
    output logic [DW-1:0]     rsp_dat,
    output logic              busy,
    output logic [31:0]       hbus_adr_o,
    output logic [15:0]       hbus_dat_o,
    input  logic [15:0]       hbus_dat_i,
    output logic              hbus_rrq,
    output logic              hbus_wrq,
    input  logic              hbus_ready,
    input  logic              hbus_valid
);
    localparam int unsigned BEATS = DW / 16;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNW   = AW + 1;
    localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT + 1);
    localparam int unsigned EW    = 1 + 32 + DW;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ptr_q, ptr_d, gnt_q, gnt_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              first_q, first_d, seen_q, seen_d;
    logic              cur_we_q, cur_we_d;
    logic [31:0]       cur_adr_q, cur_adr_d;
    logic [DW-1:0]     cur_dat_q, cur_dat_d, asm_q, asm_d;
    logic [AW-1:0]     wr_ptr_q [NCH];
    logic [AW-1:0]     wr_ptr_d [NCH];
    logic [AW-1:0]     rd_ptr_q [NCH];
    logic [AW-1:0]     rd_ptr_d [NCH];
    logic [CNW-1:0]    cnt_q [NCH];
    logic [CNW-1:0]    cnt_d [NCH];
    logic [EW-1:0]     mem_q [NCH][DEPTH];
    logic [NCH-1:0]    cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d, busy_q, busy_d;
    logic [DW-1:0]     rsp_dat_q, rsp_dat_d;
    logic [31:0]       hbus_adr_q, hbus_adr_d;
    logic [15:0]       hbus_dat_q, hbus_dat_d;
    logic              rrq_q, rrq_d, wrq_q, wrq_d;

    logic [NCH-1:0]    push, pop;
    logic              found;
    logic [CW-1:0]     sel, idx;
    logic [BW-1:0]     nbeat;
    logic [EW-1:0]     head;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        first_d     = first_q;
        seen_d      = seen_q;
        cur_we_d    = cur_we_q;
        cur_adr_d   = cur_adr_q;
        cur_dat_d   = cur_dat_q;
        asm_d       = asm_q;
        hbus_adr_d  = hbus_adr_q;
        hbus_dat_d  = hbus_dat_q;
        rrq_d       = 1'b0;
        wrq_d       = 1'b0;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = '0;
        pop         = '0;
        found       = 1'b0;
        sel         = '0;
        idx         = '0;
        nbeat       = '0;
        busy_d      = 1'b0;

        // Round-robin scan starting just after the last granted channel
        for (int k = 1; k <= int'(NCH); k++) begin
            idx = CW'((int'(ptr_q) + k) % int'(NCH));
            if (!found && cnt_q[idx] != '0) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        head = mem_q[sel][rd_ptr_q[sel]];

        case (state_q)
            IDLE: begin
                if (hbus_ready && found) begin
                    state_d    = ISSUE;
                    gnt_d      = sel;
                    ptr_d      = sel;
                    cur_we_d   = head[EW-1];
                    cur_adr_d  = head[DW +: 32];
                    cur_dat_d  = head[DW-1:0];
                    beat_d     = '0;
                    tmo_d      = '0;
                    asm_d      = '0;
                    hbus_adr_d = head[DW +: 32];
                    hbus_dat_d = head[15:0];
                    wrq_d      = head[EW-1];
                    rrq_d      = !head[EW-1];
                end
            end
            ISSUE: begin
                state_d = WAIT;
                first_d = 1'b1;
                seen_d  = 1'b0;
                tmo_d   = '0;
            end
            WAIT: begin
                first_d = 1'b0;
                tmo_d   = tmo_q + 1'b1;
                if (!cur_we_q && hbus_valid) begin
                    asm_d[16*int'(beat_q) +: 16] = hbus_dat_i;
                    seen_d = 1'b1;
                end
                // Ready is stale on the first WAIT cycle while the core drops it
                if (!first_q && hbus_ready && (cur_we_q || seen_q || hbus_valid)) begin
                    if (beat_q != BW'(BEATS - 1)) begin
                        nbeat      = beat_q + 1'b1;
                        beat_d     = nbeat;
                        state_d    = ISSUE;
                        tmo_d      = '0;
                        hbus_adr_d = cur_adr_q + 32'(nbeat);
                        hbus_dat_d = cur_dat_q[16*int'(nbeat) +: 16];
                        wrq_d      = cur_we_q;
                        rrq_d      = !cur_we_q;
                    end else begin
                        state_d          = DONE;
                        rsp_valid_d[gnt_q] = 1'b1;
                        rsp_dat_d        = cur_we_q ? '0 : asm_d;
                    end
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d          = DONE;
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d        = 1'b1;
                end
            end
            DONE: begin
                state_d    = IDLE;
                pop[gnt_q] = 1'b1;
                beat_d     = '0;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        for (int i = 0; i < int'(NCH); i++) begin
            push[i]        = cmd_valid[i] & cmd_ready_q[i];
            wr_ptr_d[i]    = wr_ptr_q[i] + AW'(push[i]);
            rd_ptr_d[i]    = rd_ptr_q[i] + AW'(pop[i]);
            cnt_d[i]       = cnt_q[i] + CNW'(push[i]) - CNW'(pop[i]);
            cmd_ready_d[i] = (cnt_d[i] != CNW'(DEPTH));
            busy_d         = busy_d | (cnt_d[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i]] <= {cmd_we[i], cmd_adr[32*i +: 32], cmd_dat[DW*i +: DW]};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            ptr_q       <= CW'(NCH - 1);
            gnt_q       <= '0;
            beat_q      <= '0;
            tmo_q       <= '0;
            first_q     <= 1'b0;
            seen_q      <= 1'b0;
            cur_we_q    <= 1'b0;
            cur_adr_q   <= '0;
            cur_dat_q   <= '0;
            asm_q       <= '0;
            cmd_ready_q <= '1;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
            busy_q      <= 1'b0;
            hbus_adr_q  <= '0;
            hbus_dat_q  <= '0;
            rrq_q       <= 1'b0;
            wrq_q       <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            first_q     <= first_d;
            seen_q      <= seen_d;
            cur_we_q    <= cur_we_d;
            cur_adr_q   <= cur_adr_d;
            cur_dat_q   <= cur_dat_d;
            asm_q       <= asm_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
            busy_q      <= busy_d;
            hbus_adr_q  <= hbus_adr_d;
            hbus_dat_q  <= hbus_dat_d;
            rrq_q       <= rrq_d;
            wrq_q       <= wrq_d;
            for (int i = 0; i < int'(NCH); i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_dat    = rsp_dat_q;
    assign busy       = busy_q;
    assign hbus_adr_o = hbus_adr_q;
    assign hbus_dat_o = hbus_dat_q;
    assign hbus_rrq   = rrq_q;
    assign hbus_wrq   = wrq_q;
endmodule

// File: tb/tb_hyperbus_port_arbiter.sv
// Directed bench for hyperbus_port_arbiter with a simple core model that logs
// every request and every response for per-scenario comparison.
module tb_hyperbus_port_arbiter;
    localparam int unsigned NCH = 2, DW = 32, DEPTH = 4, TMO = 40;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NCH-1:0]    cmd_valid, cmd_ready, cmd_we, rsp_valid;
    logic [NCH*32-1:0] cmd_adr;
    logic [NCH*DW-1:0] cmd_dat;
    logic              rsp_err, busy, hbus_rrq, hbus_wrq, hbus_ready, hbus_valid;
    logic [DW-1:0]     rsp_dat;
    logic [31:0]       hbus_adr_o;
    logic [15:0]       hbus_dat_o, hbus_dat_i;

    int vectors = 0, miscompares = 0, cyc = 0;
    bit hold = 0, hang = 0;

    logic [31:0] lg_adr[$];
    logic [15:0] lg_dat[$];
    logic        lg_wr[$];
    int          lg_cyc[$];
    logic [1:0]  rs_ch[$];
    logic        rs_err[$];
    logic [31:0] rs_dat[$];
    int          rs_cyc[$];
    logic [15:0] rd_q[$];

    hyperbus_port_arbiter #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_dat(rsp_dat), .busy(busy), .hbus_adr_o(hbus_adr_o), .hbus_dat_o(hbus_dat_o),
        .hbus_dat_i(hbus_dat_i), .hbus_rrq(hbus_rrq), .hbus_wrq(hbus_wrq),
        .hbus_ready(hbus_ready), .hbus_valid(hbus_valid));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Core model: drops ready for three cycles after each request, returns read data on the last
    int  lat = 0;
    bit  pend_rd = 0;
    always @(negedge clk) begin
        if (!rstn) begin
            lat = 0; hbus_valid = 1'b0; hbus_ready = 1'b1; hbus_dat_i = 16'h0;
        end else begin
            hbus_valid = 1'b0;
            if (hbus_rrq || hbus_wrq) begin
                lg_adr.push_back(hbus_adr_o); lg_dat.push_back(hbus_dat_o);
                lg_wr.push_back(hbus_wrq); lg_cyc.push_back(cyc);
                lat = 3; pend_rd = hbus_rrq;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0 && pend_rd && !hang) begin
                    hbus_valid = 1'b1;
                    hbus_dat_i = (rd_q.size() > 0) ? rd_q.pop_front() : 16'h0;
                end
            end
            hbus_ready = !hold && lat == 0;
            if (|rsp_valid) begin
                rs_ch.push_back(rsp_valid); rs_err.push_back(rsp_err);
                rs_dat.push_back(rsp_dat); rs_cyc.push_back(cyc);
            end
        end
    end

    task automatic push(input int ch, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        @(negedge clk);
        cmd_we[ch] = we; cmd_adr[32*ch +: 32] = adr; cmd_dat[DW*ch +: DW] = dat; cmd_valid[ch] = 1'b1;
        @(posedge clk); #1;
        cmd_valid[ch] = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget, output bit ok);
        ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (rs_ch.size() >= n) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; cmd_valid = '0; cmd_we = '0; cmd_adr = '0; cmd_dat = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        vectors++;
        if (rsp_err !== 1'b0 || hbus_rrq !== 1'b0) begin
            miscompares++; $display("FAIL reset_in: err=%b rrq=%b want 0 0", rsp_err, hbus_rrq);
        end
        rstn = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (cmd_ready !== 2'b11) begin miscompares++; $display("FAIL reset_ready: got %b want 11", cmd_ready); end
        vectors++;
        if (busy !== 1'b0 || rsp_valid !== 2'b00) begin
            miscompares++; $display("FAIL reset_idle: busy=%b rsp_valid=%b want 0 00", busy, rsp_valid);
        end
        vectors++;
        if (hbus_wrq !== 1'b0 || hbus_adr_o !== 32'h0) begin
            miscompares++; $display("FAIL reset_bus: wrq=%b adr=%h want 0 0", hbus_wrq, hbus_adr_o);
        end
    endtask

    task automatic test_back_to_back();
        int rb, lb; bit ok;
        rb = rs_ch.size(); lb = lg_adr.size();
        hold = 1; repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int ch = 0; ch < 2; ch++) begin
                cmd_we[ch] = 1'b1; cmd_adr[32*ch +: 32] = 32'h100 * ch + 4 * k;
                cmd_dat[DW*ch +: DW] = {8'hA0, 8'(ch), 8'hB0, 8'(k)};
            end
            cmd_valid = 2'b11;
            @(posedge clk); #1;
            cmd_valid = 2'b00;
        end
        hold = 0;
        wait_rsp(rb + 6, 300, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got %0d rsps want %0d", rs_ch.size() - rb, 6); end
        for (int j = 0; j < 6; j++) begin
            int ch, k;
            ch = j % 2; k = j / 2;
            vectors++;
            if (rs_ch[rb+j] !== 2'(1 << ch)) begin
                miscompares++; $display("FAIL b2b_grant%0d: got %b want %b", j, rs_ch[rb+j], 2'(1 << ch));
            end
            vectors++;
            if (lg_adr[lb+2*j] !== 32'(32'h100 * ch + 4 * k) || lg_adr[lb+2*j+1] !== 32'(32'h100 * ch + 4 * k + 1)) begin
                miscompares++; $display("FAIL b2b_adr%0d: got %h,%h want %h,+1", j, lg_adr[lb+2*j], lg_adr[lb+2*j+1], 32'h100 * ch + 4 * k);
            end
            vectors++;
            if (lg_dat[lb+2*j] !== {8'hB0, 8'(k)} || lg_dat[lb+2*j+1] !== {8'hA0, 8'(ch)}) begin
                miscompares++; $display("FAIL b2b_dat%0d: got %h,%h want %h,%h", j, lg_dat[lb+2*j], lg_dat[lb+2*j+1], {8'hB0, 8'(k)}, {8'hA0, 8'(ch)});
            end
        end
    endtask

    task automatic test_single_write();
        int rb, lb; bit ok;
        rb = rs_ch.size(); lb = lg_adr.size();
        push(0, 1'b1, 32'h10, 32'hdeadbeef);
        @(negedge clk); #1;
        vectors++;
        if (hbus_wrq !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL wr_grant_cycle: wrq=%b busy=%b want 0 1", hbus_wrq, busy);
        end
        @(negedge clk); #1;
        vectors++;
        if (hbus_wrq !== 1'b1 || hbus_adr_o !== 32'h10 || hbus_dat_o !== 16'hbeef) begin
            miscompares++; $display("FAIL wr_first_req: wrq=%b adr=%h dat=%h want 1 10 beef", hbus_wrq, hbus_adr_o, hbus_dat_o);
        end
        wait_rsp(rb + 1, 100, ok);
        vectors++;
        if (!ok || lg_adr.size() != lb + 2) begin
            miscompares++; $display("FAIL wr_count: got %0d reqs want 2", lg_adr.size() - lb);
        end
        vectors++;
        if (lg_adr[lb+1] !== 32'h11 || lg_dat[lb+1] !== 16'hdead || lg_wr[lb+1] !== 1'b1) begin
            miscompares++; $display("FAIL wr_second: adr=%h dat=%h wr=%b want 11 dead 1", lg_adr[lb+1], lg_dat[lb+1], lg_wr[lb+1]);
        end
        vectors++;
        if (rs_ch[rb] !== 2'b01 || rs_err[rb] !== 1'b0 || rs_dat[rb] !== 32'h0) begin
            miscompares++; $display("FAIL wr_rsp: ch=%b err=%b dat=%h want 01 0 0", rs_ch[rb], rs_err[rb], rs_dat[rb]);
        end
    endtask

    task automatic test_read_wrap();
        int rb, lb; bit ok;
        logic [31:0] exp_a [2];
        logic [31:0] exp_d [2];
        exp_a[0] = 32'hfffffffe; exp_a[1] = 32'hffffffff;
        exp_d[0] = 32'h56781234; exp_d[1] = 32'h5555aaaa;
        rb = rs_ch.size(); lb = lg_adr.size();
        rd_q.push_back(16'h1234); rd_q.push_back(16'h5678);
        rd_q.push_back(16'haaaa); rd_q.push_back(16'h5555);
        push(0, 1'b0, exp_a[0], 32'h0);
        push(0, 1'b0, exp_a[1], 32'h0);
        wait_rsp(rb + 2, 150, ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rd_timeout: got %0d rsps want 2", rs_ch.size() - rb); end
        for (int j = 0; j < 2; j++) begin
            vectors++;
            if (lg_adr[lb+2*j] !== exp_a[j] || lg_adr[lb+2*j+1] !== exp_a[j] + 32'h1 || lg_wr[lb+2*j] !== 1'b0) begin
                miscompares++; $display("FAIL rd_adr%0d: got %h,%h wr=%b want %h,%h 0", j, lg_adr[lb+2*j], lg_adr[lb+2*j+1], lg_wr[lb+2*j], exp_a[j], exp_a[j] + 32'h1);
            end
            vectors++;
            if (rs_ch[rb+j] !== 2'b01 || rs_err[rb+j] !== 1'b0 || rs_dat[rb+j] !== exp_d[j]) begin
                miscompares++; $display("FAIL rd_rsp%0d: ch=%b err=%b dat=%h want 01 0 %h", j, rs_ch[rb+j], rs_err[rb+j], rs_dat[rb+j], exp_d[j]);
            end
        end
    endtask

    task automatic test_fill();
        int rb, lb; bit ok;
        rb = rs_ch.size(); lb = lg_adr.size();
        hold = 1; repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) push(1, 1'b1, 32'h200 + 4 * k, {8'hC1, 8'(k), 8'hD1, 8'(k)});
        vectors++;
        if (cmd_ready !== 2'b01) begin miscompares++; $display("FAIL fill_full: got %b want 01", cmd_ready); end
        push(1, 1'b1, 32'h2f0, 32'hffffffff);
        vectors++;
        if (cmd_ready !== 2'b01 || busy !== 1'b1 || lg_adr.size() != lb) begin
            miscompares++; $display("FAIL fill_blocked: ready=%b busy=%b reqs=%0d want 01 1 0", cmd_ready, busy, lg_adr.size() - lb);
        end
        hold = 0;
        wait_rsp(rb + 4, 200, ok);
        repeat (30) @(negedge clk);
        #1;
        vectors++;
        if (!ok || rs_ch.size() != rb + 4 || lg_adr.size() != lb + 8) begin
            miscompares++; $display("FAIL fill_count: rsps=%0d reqs=%0d want 4 8", rs_ch.size() - rb, lg_adr.size() - lb);
        end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (rs_ch[rb+k] !== 2'b10 || lg_adr[lb+2*k] !== 32'(32'h200 + 4 * k) || lg_dat[lb+2*k+1] !== {8'hC1, 8'(k)}) begin
                miscompares++; $display("FAIL fill_order%0d: ch=%b adr=%h dat=%h want 10 %h %h", k, rs_ch[rb+k], lg_adr[lb+2*k], lg_dat[lb+2*k+1], 32'h200 + 4 * k, {8'hC1, 8'(k)});
            end
        end
    endtask

    task automatic test_timeout();
        int rb, lb; bit ok;
        rb = rs_ch.size(); lb = lg_adr.size();
        hang = 1;
        push(0, 1'b0, 32'h40, 32'h0);
        push(0, 1'b1, 32'h50, 32'h11112222);
        wait_rsp(rb + 1, TMO + 50, ok);
        vectors++;
        if (!ok || rs_ch[rb] !== 2'b01 || rs_err[rb] !== 1'b1 || rs_dat[rb] !== 32'h0) begin
            miscompares++; $display("FAIL tmo_rsp: ch=%b err=%b dat=%h want 01 1 0", rs_ch[rb], rs_err[rb], rs_dat[rb]);
        end
        vectors++;
        if (lg_adr.size() != lb + 1 || rs_cyc[rb] - lg_cyc[lb] != TMO + 1) begin
            miscompares++; $display("FAIL tmo_timing: reqs=%0d cycles=%0d want 1 %0d", lg_adr.size() - lb, rs_cyc[rb] - lg_cyc[lb], TMO + 1);
        end
        hang = 0;
        wait_rsp(rb + 2, 100, ok);
        vectors++;
        if (!ok || rs_err[rb+1] !== 1'b0 || lg_adr[lb+1] !== 32'h50 || lg_dat[lb+1] !== 16'h2222 || lg_wr[lb+1] !== 1'b1) begin
            miscompares++; $display("FAIL tmo_next: err=%b adr=%h dat=%h want 0 50 2222", rs_err[rb+1], lg_adr[lb+1], lg_dat[lb+1]);
        end
    endtask

    task automatic test_reset_mid();
        int rb, lb; bit seen;
        seen = 0;
        hang = 1;
        push(0, 1'b0, 32'h300, 32'h0);
        push(0, 1'b0, 32'h304, 32'h0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (hbus_rrq) begin seen = 1; break; end
        end
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        #1;
        vectors++;
        if (!seen || hbus_rrq !== 1'b0 || hbus_wrq !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_drop: seen=%b rrq=%b wrq=%b busy=%b want 1 0 0 0", seen, hbus_rrq, hbus_wrq, busy);
        end
        rb = rs_ch.size(); lb = lg_adr.size();
        hang = 0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (cmd_ready !== 2'b11 || busy !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_release: ready=%b busy=%b want 11 0", cmd_ready, busy);
        end
        repeat (30) @(negedge clk);
        #1;
        vectors++;
        if (rs_ch.size() != rb || lg_adr.size() != lb) begin
            miscompares++; $display("FAIL rst_mid_lost: rsps=%0d reqs=%0d want 0 0", rs_ch.size() - rb, lg_adr.size() - lb);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_single_write();
        test_read_wrap();
        test_fill();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hyperbus_port_arbiter.md
Name: hyperbus_port_arbiter

Overview:
Parametrised multi-channel successor to hyperbus_fifo. Sits between NCH independent user command ports and a single hyperbus core request interface (rrq/wrq/ready/valid, 16-bit data). Each port has its own command queue. A round-robin arbiter selects one queued command at a time and splits each DW-bit command into DW/16 halfword core transactions. Read data is reassembled and returned per port, and a hung core transaction is reported through a timeout error.

Parameters:
NCH, 2, number of user channels (1..8)
DW, 32, user data width; multiple of 16; BEATS = DW/16
DEPTH, 4, command queue entries per channel; power of 2, at least 2
TIMEOUT, 1024, cycles allowed in WAIT before the command is aborted

Ports:
clk  in  1  block clock; same clock as the hyperbus core
rstn  in  1  reset; asynchronous, active-low
cmd_valid  in  NCH  per-channel command valid
cmd_ready  out  NCH  per-channel queue not full
cmd_we  in  NCH  1 = write, 0 = read
cmd_adr  in  NCH*32  per-channel start address; channel i occupies [32i+31:32i]
cmd_dat  in  NCH*DW  per-channel write data; channel i occupies [DW*i+DW-1:DW*i]
rsp_valid  out  NCH  one-hot, 1-cycle pulse: command completed
rsp_err  out  1  qualifies rsp_valid: command aborted by timeout
rsp_dat  out  DW  read data, valid with rsp_valid for reads
busy  out  1  state is not IDLE, or any queue is non-empty
hbus_adr_o  out  32  core address
hbus_dat_o  out  16  core write halfword
hbus_dat_i  in  16  core read halfword
hbus_rrq  out  1  core read request, 1-cycle pulse
hbus_wrq  out  1  core write request, 1-cycle pulse
hbus_ready  in  1  core idle, can accept a request
hbus_valid  in  1  core read data valid, 1-cycle pulse

Behaviour:
Reset (rstn low, asynchronous):
- All queues flushed; state goes to IDLE; round-robin pointer = NCH-1; beat counter and timeout counter cleared.
- cmd_ready = all-ones on the first cycle after reset release.
- All other outputs are 0 while in reset, including hbus_rrq and hbus_wrq, which drop immediately even mid-transaction.
- Any in-flight command is lost and produces no rsp_valid.

Queues:
- Push when cmd_valid[i] & cmd_ready[i].
- cmd_ready[i] = queue i not full.
- Simultaneous push and pop on a full queue is not allowed; cmd_ready stays low while the queue is full.

Arbitration (IDLE, and only when hbus_ready = 1):
- Grant the first non-empty channel scanning from pointer+1 upward, with wrap.
- The pointer is set to the granted channel.
- A command pushed at cycle t can be granted at t+1, and its first request is asserted at t+2.

FSM states: IDLE, ISSUE, WAIT, DONE.
- ISSUE (1 cycle): assert hbus_wrq or hbus_rrq.
  - hbus_adr_o = cmd_adr + beat, modulo 2^32, so the address wraps.
  - hbus_dat_o = cmd_dat[16*beat+15 : 16*beat].
  - beat counts 0..BEATS-1. The first beat carries the low halfword.
- WAIT:
  - hbus_ready is ignored on the first WAIT cycle, because the core is still dropping ready.
  - Read: on hbus_valid, capture hbus_dat_i into assembly slot [beat].
  - Write: exit on hbus_ready = 1.
  - Read: exit once hbus_valid has been seen and hbus_ready = 1.
  - On exit, if beat < BEATS-1, increment beat and go to ISSUE; otherwise go to DONE.
  - The timeout counter resets on every ISSUE. If it reaches TIMEOUT in WAIT, go to DONE with the error flag set.
- DONE (1 cycle):
  - Pulse rsp_valid[granted].
  - rsp_err = error flag.
  - rsp_dat = assembled data for reads; 0 for writes and for errors.
  - Pop the granted queue, clear beat, go to IDLE.
- hbus_adr_o and hbus_dat_o hold their values from ISSUE until the next ISSUE.
- Commands from one channel complete in push order. There is no ordering guarantee across channels.

Test Plan:
- Single channel: write 32'hdeadbeef to 32'h00000010 -> two wrq pulses: adr 0x10 with dat 0xbeef, then adr 0x11 with dat 0xdead; then rsp_valid = 2'b01, rsp_err = 0.
- Read at 32'hfffffffe with core returning 0x1234, then 0x5678 -> adr 0xfffffffe, then 0xffffffff; rsp_dat = 32'h56781234 on rsp_valid[0]; wrap checked by also reading at 0xffffffff, whose second beat goes to adr 0x0.
- Both channels issue back-to-back writes continuously -> grants alternate 0,1,0,1; no channel waits more than one command.
- Fill channel 1 with DEPTH commands while hbus_ready = 0 -> cmd_ready[1] = 0 after the 4th push; the 5th push is not accepted; all 4 complete in order once ready rises.
- Core never returns hbus_valid on a read -> after TIMEOUT cycles, rsp_valid[i] = 1 with rsp_err = 1 and rsp_dat = 0; the next queued command proceeds.
- Assert rstn low during WAIT -> hbus_rrq and hbus_wrq drop immediately; after release, cmd_ready = all-ones, busy = 0, and no rsp_valid is produced.
